// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side hazard and forwarding unit for the in-order MIPS pipeline.
// Tracks in-flight register writes with their age and result latency, plus one outstanding
// multi-cycle (mul/div) destination. From that state it produces per-operand forwarding
// selects, a decode stall and a saturating count of stall cycles.
module hazard_scoreboard #(
  parameter int AW        = 5,
  parameter int NSRC      = 2,
  parameter int DEPTH     = 3,
  parameter int LAT_W     = 2,
  parameter int SEL_W     = 2,
  parameter int FLUSH_AGE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [NSRC*AW-1:0]    issue_src_i,
  input  logic [NSRC-1:0]       issue_src_used_i,
  input  logic                  issue_we_i,
  input  logic [AW-1:0]         issue_dst_i,
  input  logic [LAT_W-1:0]      issue_lat_i,
  input  logic                  issue_long_i,
  input  logic                  lng_done_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [NSRC*SEL_W-1:0] fwd_sel_o,
  output logic                  lng_busy_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int NREG = 2 ** AW;

  // Per-register scoreboard; index 0 is never written outside reset, so it never forwards
  logic             pend_q [NREG];
  logic [SEL_W-1:0] age_q  [NREG];
  logic [LAT_W-1:0] lat_q  [NREG];

  // Single outstanding long-latency destination
  logic          lng_v_q;
  logic [AW-1:0] lng_dst_q;

  logic [CNT_W-1:0] stall_cnt_q;

  logic          op_hazard;
  logic [AW-1:0] op_src;
  logic          struct_hazard;
  logic          waw_hazard;
  logic          issue_ok;
  logic [LAT_W-1:0] issue_lat_eff;

  // Operand check: a source waits on the long unit or on a result not yet produced,
  // otherwise it forwards from the stage its producer currently occupies
  always_comb begin
    op_hazard = 1'b0;
    op_src    = '0;
    fwd_sel_o = '0;
    for (int s = 0; s < NSRC; s++) begin
      op_src = issue_src_i[s*AW +: AW];
      if (issue_src_used_i[s] && (op_src != '0)) begin
        if (lng_v_q && (op_src == lng_dst_q)) begin
          op_hazard = 1'b1;
        end else if (pend_q[op_src] && (int'(age_q[op_src]) < int'(lat_q[op_src]))) begin
          op_hazard = 1'b1;
        end else if (pend_q[op_src]) begin
          fwd_sel_o[s*SEL_W +: SEL_W] = age_q[op_src];
        end
      end
    end
  end

  // The long unit is single-slot, and a write to its pending destination would race it
  assign struct_hazard = issue_long_i & lng_v_q;
  assign waw_hazard    = issue_we_i & lng_v_q & (issue_dst_i == lng_dst_q);
  assign stall_o       = issue_valid_i & (op_hazard | struct_hazard | waw_hazard);

  assign issue_ok      = issue_valid_i & ~stall_o & ~flush_i & issue_we_i & (issue_dst_i != '0);
  assign issue_lat_eff = (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;

  // Scoreboard update: a new writer replaces the entry, otherwise entries age, die at
  // writeback, or are killed by a flush while still young
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= 1'b0;
        age_q[r]  <= '0;
        lat_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_ok && !issue_long_i && (issue_dst_i == AW'(r))) begin
          pend_q[r] <= 1'b1;
          age_q[r]  <= SEL_W'(1);
          lat_q[r]  <= issue_lat_eff;
        end else if (pend_q[r]) begin
          if (flush_i && (int'(age_q[r]) <= FLUSH_AGE)) begin
            pend_q[r] <= 1'b0;
          end else if (int'(age_q[r]) >= DEPTH) begin
            pend_q[r] <= 1'b0;
          end else begin
            age_q[r] <= age_q[r] + 1'b1;
          end
        end
      end
    end
  end

  // Long slot: set on an accepted long issue, released when the unit writes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lng_v_q   <= 1'b0;
      lng_dst_q <= '0;
    end else if (issue_ok && issue_long_i) begin
      lng_v_q   <= 1'b1;
      lng_dst_q <= issue_dst_i;
    end else if (lng_done_i) begin
      lng_v_q   <= 1'b0;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign lng_busy_o  = lng_v_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors push hand-computed expectations into a queue,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [9:0] issue_src;
  logic [1:0] issue_src_used;
  logic       issue_we;
  logic [4:0] issue_dst;
  logic [1:0] issue_lat;
  logic       issue_long;
  logic       lng_done;
  logic       flush;
  logic       stall;
  logic [3:0] fwd_sel;
  logic       lng_busy;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       stall;
    logic [3:0] fwd;
    logic       busy;
    logic       chk_cnt;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  hazard_scoreboard #(.CNT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_src_i      (issue_src),
    .issue_src_used_i (issue_src_used),
    .issue_we_i       (issue_we),
    .issue_dst_i      (issue_dst),
    .issue_lat_i      (issue_lat),
    .issue_long_i     (issue_long),
    .lng_done_i       (lng_done),
    .flush_i          (flush),
    .stall_o          (stall),
    .fwd_sel_o        (fwd_sel),
    .lng_busy_o       (lng_busy),
    .stall_cnt_o      (stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string nm, input string field, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0d expected=%0d", nm, field, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation in the middle of its cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checkOutput(mon_nm, "stall", 32'(stall), 32'(mon_e.stall));
      checkOutput(mon_nm, "busy", 32'(lng_busy), 32'(mon_e.busy));
      if (!mon_e.stall) checkOutput(mon_nm, "fwd_sel", 32'(fwd_sel), 32'(mon_e.fwd));
      if (mon_e.chk_cnt) checkOutput(mon_nm, "stall_cnt", 32'(stall_cnt), 32'(mon_e.cnt));
    end
  end

  task automatic applyStimulus(input string nm, input logic rst_v, input logic v,
                               input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                               input logic we, input logic [4:0] dst, input logic [1:0] lat,
                               input logic lng, input logic done, input logic fl,
                               input logic e_stall, input logic [3:0] e_fwd, input logic e_busy,
                               input logic c_cnt, input logic [3:0] e_cnt);
    exp_t e;
    rst_n          = rst_v;
    issue_valid    = v;
    issue_src      = {s1, s0};
    issue_src_used = used;
    issue_we       = we;
    issue_dst      = dst;
    issue_lat      = lat;
    issue_long     = lng;
    lng_done       = done;
    flush          = fl;
    e.stall   = e_stall;
    e.fwd     = e_fwd;
    e.busy    = e_busy;
    e.chk_cnt = c_cnt;
    e.cnt     = e_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    issue_valid    = 1'b0;
    issue_src      = '0;
    issue_src_used = '0;
    issue_we       = 1'b0;
    issue_dst      = '0;
    issue_lat      = '0;
    issue_long     = 1'b0;
    lng_done       = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic resetDut();
    idleInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state: nothing tracked
    applyStimulus("reset_state", 1, 1, 5'd3, 5'd4, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd0);

    // ALU forwarding through E, M, W, then register file
    applyStimulus("alu_issue", 1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd3, 2'd1, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("alu_fwd_e", 1, 1, 5'd3, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h1, 0, 0, 4'd0);
    applyStimulus("alu_fwd_m", 1, 1, 5'd3, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h2, 0, 0, 4'd0);
    applyStimulus("alu_fwd_w", 1, 1, 5'd3, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h3, 0, 0, 4'd0);
    applyStimulus("alu_rf",    1, 1, 5'd3, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd0);

    // Register 0 and unused operand, then load-use on r4 (overwrite of aging entry)
    applyStimulus("r4_issue",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd4, 2'd2, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("r0_unused", 1, 1, 5'd0, 5'd4, 2'b01, 1, 5'd0, 2'd2, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("r0_read",   1, 1, 5'd0, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("ld_issue",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd4, 2'd2, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("ld_stall",  1, 1, 5'd0, 5'd4, 2'b10, 0, 5'd0, 2'd0, 0, 0, 0, 1, 4'h0, 0, 1, 4'd0);
    applyStimulus("ld_fwd_m",  1, 1, 5'd0, 5'd4, 2'b10, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h8, 0, 1, 4'd1);

    // Long-latency op, structural and WAW hazards, issue colliding with done
    resetDut();
    applyStimulus("lng_issue", 1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd5, 2'd0, 1, 0, 0, 0, 4'h0, 0, 1, 4'd0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus($sformatf("lng_wait%0d", k), 1, 1, 5'd5, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0,
                    1, 4'h0, 1, 1, 4'(k - 1));
    end
    applyStimulus("lng_done",  1, 1, 5'd5, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 1, 0, 1, 4'h0, 1, 1, 4'd9);
    applyStimulus("lng_rf",    1, 1, 5'd5, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd10);
    applyStimulus("lng2_issue",1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd6, 2'd0, 1, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("lng_struct",1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 2'd0, 1, 0, 0, 1, 4'h0, 1, 0, 4'd0);
    applyStimulus("lng_waw",   1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd6, 2'd1, 0, 0, 0, 1, 4'h0, 1, 0, 4'd0);
    applyStimulus("lng_coll",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 2'd0, 1, 1, 0, 1, 4'h0, 1, 0, 4'd0);
    applyStimulus("lng3_issue",1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 2'd0, 1, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("lng3_use",  1, 1, 5'd0, 5'd7, 2'b10, 0, 5'd0, 2'd0, 0, 0, 0, 1, 4'h0, 1, 1, 4'd13);
    applyStimulus("lng3_done", 1, 0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 2'd0, 0, 1, 0, 0, 4'h0, 1, 1, 4'd14);

    // Overwrite (youngest writer wins) and flush of young entries only
    resetDut();
    applyStimulus("ow_first",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd6, 2'd1, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("ow_second", 1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd6, 2'd2, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("ow_stall",  1, 1, 5'd6, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 1, 4'h0, 0, 0, 4'd0);
    applyStimulus("ow_fwd_m",  1, 1, 5'd6, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h2, 0, 0, 4'd0);
    applyStimulus("fl_r8",     1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd8, 2'd1, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("fl_r7",     1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 2'd1, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("fl_flush",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd9, 2'd1, 0, 0, 1, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("fl_after",  1, 1, 5'd7, 5'd8, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'hC, 0, 0, 4'd0);
    applyStimulus("fl_blocked",1, 1, 5'd9, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd1);

    // Asynchronous reset in the middle of a load-use stall, then counter saturation
    resetDut();
    applyStimulus("rs_issue",  1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd4, 2'd3, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0);
    applyStimulus("rs_stall1", 1, 1, 5'd4, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 1, 4'h0, 0, 1, 4'd0);
    applyStimulus("rs_stall2", 1, 1, 5'd4, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 1, 4'h0, 0, 1, 4'd1);
    applyStimulus("rs_async",  0, 1, 5'd4, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd0);
    applyStimulus("rs_release",1, 1, 5'd4, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd0);
    applyStimulus("sat_issue", 1, 1, 5'd0, 5'd0, 2'b00, 1, 5'd10, 2'd0, 1, 0, 0, 0, 4'h0, 0, 1, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus($sformatf("sat%0d", k), 1, 1, 5'd10, 5'd0, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0,
                    1, 4'h0, 1, 1, (k - 1 > 15) ? 4'd15 : 4'(k - 1));
    end
    applyStimulus("sat_final", 1, 0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 2'd0, 0, 1, 0, 0, 4'h0, 1, 1, 4'd15);
    applyStimulus("sat_idle",  1, 0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 2'd0, 0, 0, 0, 0, 4'h0, 0, 1, 4'd15);

    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
